// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// Outputs only change on a completed conversion or an error bypass.
module bin2bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  negative_in,
  input  logic                  overflow_in,
  input  logic                  error_in,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  sign,
  output logic                  ovf,
  output logic                  err,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          r_state;
  logic [WIDTH-1:0] r_sr;
  logic [BW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_neg;
  logic            r_ovf;
  logic            r_err;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_acc_nxt;
  logic [WIDTH-1:0] w_sr_nxt;
  logic             w_last;

  // Add-3 correction keeps each digit <= 12, so no inter-digit carry.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_acc[4*i+:4] >= 4'd5)
        w_adj[4*i+:4] = r_acc[4*i+:4] + 4'd3;
      else
        w_adj[4*i+:4] = r_acc[4*i+:4];
    end
    w_acc_nxt = BW'({w_adj, r_sr[WIDTH-1]});
    w_sr_nxt  = {r_sr[WIDTH-2:0], 1'b0};
    w_last    = (r_cnt == CW'(WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      bcd     <= '0;
      sign    <= 1'b0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
          if (start && error_in) begin
            bcd     <= {BW{1'b1}};
            sign    <= 1'b0;
            ovf     <= overflow_in;
            err     <= 1'b1;
            done    <= 1'b1;
            r_state <= DONE;
          end else if (start) begin
            r_sr    <= value;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= negative_in;
            r_ovf   <= overflow_in;
            r_err   <= error_in;
            busy    <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc <= w_acc_nxt;
          r_sr  <= w_sr_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            bcd     <= w_acc_nxt;
            sign    <= r_neg;
            ovf     <= r_ovf;
            err     <= r_err;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq with a result scoreboard.
// Expected BCD comes from a decimal divide-by-ten model.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] value;
  logic        negative_in;
  logic        overflow_in;
  logic        error_in;
  logic [39:0] bcd;
  logic        sign;
  logic        ovf;
  logic        err;
  logic        busy;
  logic        done;

  int nerr = 0;
  int nchk = 0;

  logic [42:0] sb[$];

  bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .value       (value),
    .negative_in (negative_in),
    .overflow_in (overflow_in),
    .error_in    (error_in),
    .bcd         (bcd),
    .sign        (sign),
    .ovf         (ovf),
    .err         (err),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] bcd_of(logic [31:0] v);
    logic [39:0] r;
    logic [31:0] t;
    r = '0;
    t = v;
    for (int i = 0; i < 10; i++) begin
      r[4*i+:4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic push(logic [39:0] b, logic s, logic o, logic e);
    sb.push_back({b, s, o, e});
  endtask

  task automatic check_out(string tag);
    logic [42:0] e;
    nchk++;
    if (sb.size() == 0) begin
      nerr++;
      $error("FAIL %s_sb: got empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_bcd"}, 64'(bcd), 64'(e[42:3]));
      chk({tag, "_sign"}, 64'(sign), 64'(e[2]));
      chk({tag, "_ovf"}, 64'(ovf), 64'(e[1]));
      chk({tag, "_err"}, 64'(err), 64'(e[0]));
    end
  endtask

  // One full conversion; inputs are scrambled during SHIFT on purpose.
  task automatic conv(string tag, logic [31:0] v, logic n, logic o);
    int c;
    int bcnt;
    logic hold_bad;
    logic [39:0] prev;
    value = v;
    negative_in = n;
    overflow_in = o;
    error_in = 1'b0;
    start = 1'b1;
    push(bcd_of(v), n, o, 1'b0);
    tick();
    start = 1'b0;
    value = ~v;
    negative_in = ~n;
    overflow_in = ~o;
    error_in = 1'b1;
    prev = bcd;
    bcnt = busy ? 1 : 0;
    hold_bad = 1'b0;
    c = 0;
    while (!done && c < 40) begin
      tick();
      c++;
      if (busy) bcnt++;
      if (!done && bcd !== prev) hold_bad = 1'b1;
    end
    error_in = 1'b0;
    chk({tag, "_done"}, 64'(done), 64'(1));
    chk({tag, "_lat"}, 64'(c), 64'(32));
    chk({tag, "_busycnt"}, 64'(bcnt), 64'(32));
    chk({tag, "_hold"}, 64'(hold_bad), 64'(0));
    if (done) check_out(tag);
    tick();
    chk({tag, "_done_clr"}, 64'(done), 64'(0));
  endtask

  initial begin
    int dc[$];
    int c;
    logic seen;
    rst = 1'b1;
    start = 1'b1;
    value = 32'd77;
    negative_in = 1'b1;
    overflow_in = 1'b1;
    error_in = 1'b0;
    tick();
    tick();
    chk("rst_bcd", 64'(bcd), 64'(0));
    chk("rst_sign", 64'(sign), 64'(0));
    chk("rst_ovf", 64'(ovf), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    rst = 1'b0;
    start = 1'b0;
    tick();

    conv("zero", 32'd0, 1'b0, 1'b0);
    conv("max", 32'hFFFF_FFFF, 1'b1, 1'b0);
    conv("mixed", 32'd1234567890, 1'b0, 1'b1);
    conv("nines", 32'd999999999, 1'b1, 1'b1);

    // start held high: re-accept in the DONE cycle
    value = 32'd12345;
    negative_in = 1'b0;
    overflow_in = 1'b0;
    start = 1'b1;
    push(bcd_of(32'd12345), 1'b0, 1'b0, 1'b0);
    push(bcd_of(32'd12345), 1'b0, 1'b0, 1'b0);
    tick();
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 39) start = 1'b0;
      if (done) begin
        dc.push_back(i);
        check_out("held");
      end
    end
    chk("held_ndone", 64'(dc.size()), 64'(2));
    if (dc.size() == 2) begin
      chk("held_d0", 64'(dc[0]), 64'(32));
      chk("held_d1", 64'(dc[1]), 64'(65));
    end

    // error bypass
    value = 32'd55;
    negative_in = 1'b1;
    overflow_in = 1'b1;
    error_in = 1'b1;
    start = 1'b1;
    push(40'hFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    tick();
    start = 1'b0;
    error_in = 1'b0;
    chk("errb_done", 64'(done), 64'(1));
    chk("errb_busy", 64'(busy), 64'(0));
    if (done) check_out("errb");
    tick();
    chk("errb_done_clr", 64'(done), 64'(0));
    chk("errb_busy2", 64'(busy), 64'(0));
    chk("errb_hold", 64'(bcd), 64'(40'hFF_FFFF_FFFF));

    // start during SHIFT is ignored
    value = 32'd99;
    negative_in = 1'b0;
    overflow_in = 1'b0;
    start = 1'b1;
    push(bcd_of(32'd99), 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    c = 0;
    seen = 1'b0;
    for (int i = 1; i <= 75; i++) begin
      if (i == 10) begin
        value = 32'd7;
        start = 1'b1;
      end
      tick();
      if (i == 10) start = 1'b0;
      if (done) begin
        if (!seen) c = i;
        else chk("ign_extra_done", 64'(i), 64'(0));
        seen = 1'b1;
        check_out("ign");
      end
    end
    chk("ign_seen", 64'(seen), 64'(1));
    chk("ign_lat", 64'(c), 64'(32));

    // reset mid-SHIFT aborts
    value = 32'd500;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_bcd", 64'(bcd), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("abort_quiet", 64'(seen), 64'(0));
    conv("after", 32'd500, 1'b0, 1'b0);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
